muldiv_unit: RTL and testbench

// Iterative multiply/divide engine that produces the HI/LO pair consumed by the

---
 rtl/muldiv_unit_if.sv | 38 +++
 rtl/muldiv_unit.sv | 182 ++++++++++++++++++
 tb/tb_muldiv_unit.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/muldiv_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_unit_if
//  Description : Handshake and operand/result bundle between the control unit
//                (master) and the iterative multiply/divide engine (slave).
//                  start  request an operation (sampled while busy=0)
//                  op     00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//                  a, b   operands rs / rt
//                  busy   engine occupied
//                  done   one-cycle result-valid pulse
//                  whl    hi/lo write strobe toward the register file
//                  hi, lo result pair
//  Revision    : 1.0  initial release
// ============================================================================
interface muldiv_unit_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic [1:0]       op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic             whl;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;

   modport master (
      output start, op, a, b,
      input  busy, done, whl, hi, lo
   );

   modport slave (
      input  start, op, a, b,
      output busy, done, whl, hi, lo
   );
endinterface
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_unit
//  Description : Iterative MULT/MULTU/DIV/DIVU engine, one bit per cycle.
//                Produces {hi, lo} plus a one-cycle write strobe for the
//                register file hi/lo write path.
//  Ports       : clk  rising-edge clock
//                rst  synchronous active-high reset
//                bus  muldiv_unit_if.slave (start/op/a/b in,
//                     busy/done/whl/hi/lo out)
//  Revision    : 1.0  initial release
// ============================================================================
module muldiv_unit #(
   parameter int WIDTH = 32
) (
   input  wire logic       clk,
   input  wire logic       rst,
   muldiv_unit_if.slave    bus
);

   localparam int                 c_cnt_w = $clog2(WIDTH);
   localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_FIX  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t             r_state;
   state_t             w_next;

   logic [c_cnt_w-1:0] r_cnt;
   logic [WIDTH-1:0]   r_acc_hi;   // partial product high / partial remainder
   logic [WIDTH-1:0]   r_acc_lo;   // multiplier / dividend-quotient shift reg
   logic [WIDTH-1:0]   r_opnd;     // |multiplicand| or |divisor|
   logic [WIDTH-1:0]   r_a_raw;    // unmodified a, returned as hi on b==0
   logic               r_is_div;
   logic               r_neg_q;    // negate product / quotient
   logic               r_neg_r;    // negate remainder
   logic               r_bzero;
   logic [WIDTH-1:0]   r_hi_out;
   logic [WIDTH-1:0]   r_lo_out;

   // ---------------------------------------------------------------- accept
   logic               w_is_div;
   logic               w_signed;
   logic               w_a_neg;
   logic               w_b_neg;
   logic [WIDTH-1:0]   w_a_abs;
   logic [WIDTH-1:0]   w_b_abs;

   assign w_is_div = bus.op[1];
   assign w_signed = ~bus.op[0];
   assign w_a_neg  = w_signed & bus.a[WIDTH-1];
   assign w_b_neg  = w_signed & bus.b[WIDTH-1];
   assign w_a_abs  = w_a_neg ? -bus.a : bus.a;
   assign w_b_abs  = w_b_neg ? -bus.b : bus.b;

   // ---------------------------------------------------------- iteration
   logic [WIDTH:0]     w_add;
   logic [WIDTH:0]     w_shift;
   logic [WIDTH:0]     w_diff;
   logic [WIDTH-1:0]   w_step_hi;
   logic [WIDTH-1:0]   w_step_lo;

   // Multiply: conditional add of the multiplicand, then shift the whole
   // {hi, lo} pair right so the carry lands in the top bit.
   assign w_add   = {1'b0, r_acc_hi} + {1'b0, (r_acc_lo[0] ? r_opnd : {WIDTH{1'b0}})};
   // Divide: shift the next dividend bit into the remainder and trial-subtract.
   // Bit WIDTH of the difference is the borrow (remainder < divisor always holds).
   assign w_shift = {r_acc_hi, r_acc_lo[WIDTH-1]};
   assign w_diff  = w_shift - {1'b0, r_opnd};

   always_comb begin
      w_step_hi = w_add[WIDTH:1];
      w_step_lo = {w_add[0], r_acc_lo[WIDTH-1:1]};
      if (r_is_div) begin
         if (!w_diff[WIDTH]) begin
            w_step_hi = w_diff[WIDTH-1:0];
            w_step_lo = {r_acc_lo[WIDTH-2:0], 1'b1};
         end else begin
            w_step_hi = w_shift[WIDTH-1:0];
            w_step_lo = {r_acc_lo[WIDTH-2:0], 1'b0};
         end
      end
   end

   // ---------------------------------------------------------- sign fixup
   logic [2*WIDTH-1:0] w_prod_neg;
   logic [WIDTH-1:0]   w_fix_hi;
   logic [WIDTH-1:0]   w_fix_lo;

   assign w_prod_neg = -{r_acc_hi, r_acc_lo};

   always_comb begin
      w_fix_hi = r_acc_hi;
      w_fix_lo = r_acc_lo;
      if (!r_is_div) begin
         if (r_neg_q) begin
            w_fix_hi = w_prod_neg[2*WIDTH-1:WIDTH];
            w_fix_lo = w_prod_neg[WIDTH-1:0];
         end
      end else if (r_bzero) begin
         // Divide by zero: fixed result, iteration output is discarded.
         w_fix_hi = r_a_raw;
         w_fix_lo = {WIDTH{1'b1}};
      end else begin
         if (r_neg_q) w_fix_lo = -r_acc_lo;
         if (r_neg_r) w_fix_hi = -r_acc_hi;
      end
   end

   // ------------------------------------------------------------------ FSM
   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (bus.start) w_next = S_CALC;
         S_CALC:  if (r_cnt == c_last) w_next = S_FIX;
         S_FIX:   w_next = S_DONE;
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // ------------------------------------------------------------- datapath
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt    <= '0;
         r_acc_hi <= '0;
         r_acc_lo <= '0;
         r_opnd   <= '0;
         r_a_raw  <= '0;
         r_is_div <= 1'b0;
         r_neg_q  <= 1'b0;
         r_neg_r  <= 1'b0;
         r_bzero  <= 1'b0;
         r_hi_out <= '0;
         r_lo_out <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bus.start) begin
                  r_cnt    <= '0;
                  r_acc_hi <= '0;
                  r_acc_lo <= w_is_div ? w_a_abs : w_b_abs;
                  r_opnd   <= w_is_div ? w_b_abs : w_a_abs;
                  r_a_raw  <= bus.a;
                  r_is_div <= w_is_div;
                  r_neg_q  <= w_a_neg ^ w_b_neg;
                  r_neg_r  <= w_a_neg;
                  r_bzero  <= (bus.b == '0);
               end
            end
            S_CALC: begin
               r_cnt    <= r_cnt + c_cnt_w'(1);
               r_acc_hi <= w_step_hi;
               r_acc_lo <= w_step_lo;
            end
            S_FIX: begin
               r_hi_out <= w_fix_hi;
               r_lo_out <= w_fix_lo;
            end
            default: ;
         endcase
      end
   end

   assign bus.busy = (r_state != S_IDLE);
   assign bus.done = (r_state == S_DONE);
   assign bus.whl  = (r_state == S_DONE);
   assign bus.hi   = r_hi_out;
   assign bus.lo   = r_lo_out;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_muldiv_unit
//  Description : Directed self-checking bench for muldiv_unit.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_muldiv_unit;

   localparam logic [1:0] c_mult  = 2'b00;
   localparam logic [1:0] c_multu = 2'b01;
   localparam logic [1:0] c_div   = 2'b10;
   localparam logic [1:0] c_divu  = 2'b11;

   logic clk;
   logic rst;
   int   total;
   int   bad;

   muldiv_unit_if #(.WIDTH(32)) bus ();

   muldiv_unit #(.WIDTH(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Issue one op, wait (bounded) for done, capture outputs in the done
   // cycle, then step one more edge so the caller is back in IDLE.
   task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output int busy_cnt,
                         output logic [31:0] hi, output logic [31:0] lo,
                         output logic whl, output logic done_after);
      bus.op    = op;
      bus.a     = a;
      bus.b     = b;
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      bus.a     = $urandom;
      bus.b     = $urandom;
      bus.op    = 2'($urandom_range(0, 3));
      lat       = 1;
      busy_cnt  = bus.busy ? 1 : 0;
      while (!bus.done && lat < 100) begin
         @(posedge clk);
         #1;
         lat++;
         if (bus.busy) busy_cnt++;
      end
      hi  = bus.hi;
      lo  = bus.lo;
      whl = bus.whl;
      @(posedge clk);
      #1;
      done_after = bus.done;
   endtask

   task automatic test_reset();
      rst       = 1'b1;
      bus.start = 1'b0;
      bus.op    = 2'b00;
      bus.a     = '0;
      bus.b     = '0;
      repeat (3) @(posedge clk);
      #1;
      total++; if (bus.busy !== 1'b0)  begin bad++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
      total++; if (bus.done !== 1'b0)  begin bad++; $display("FAIL reset_done got=%b exp=0", bus.done); end
      total++; if (bus.whl  !== 1'b0)  begin bad++; $display("FAIL reset_whl got=%b exp=0", bus.whl); end
      total++; if (bus.hi   !== 32'h0) begin bad++; $display("FAIL reset_hi got=%h exp=0", bus.hi); end
      total++; if (bus.lo   !== 32'h0) begin bad++; $display("FAIL reset_lo got=%h exp=0", bus.lo); end
      rst = 1'b0;
   endtask

   task automatic test_multu();
      int lat, bc; logic [31:0] hi, lo; logic whl, da;
      run_op(c_multu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, bc, hi, lo, whl, da);
      total++; if (lat !== 34)          begin bad++; $display("FAIL multu_latency got=%0d exp=34", lat); end
      total++; if (bc !== 34)           begin bad++; $display("FAIL multu_busy_cycles got=%0d exp=34", bc); end
      total++; if (hi !== 32'hFFFF_FFFE) begin bad++; $display("FAIL multu_hi got=%h exp=fffffffe", hi); end
      total++; if (lo !== 32'h0000_0001) begin bad++; $display("FAIL multu_lo got=%h exp=00000001", lo); end
      total++; if (whl !== 1'b1)        begin bad++; $display("FAIL multu_whl got=%b exp=1", whl); end
      total++; if (da !== 1'b0)         begin bad++; $display("FAIL multu_done_single got=%b exp=0", da); end
   endtask

   task automatic test_mult();
      int lat, bc; logic [31:0] hi, lo; logic whl, da;
      run_op(c_mult, 32'hFFFF_FFFD, 32'd7, lat, bc, hi, lo, whl, da);
      total++; if (hi !== 32'hFFFF_FFFF) begin bad++; $display("FAIL mult_neg_hi got=%h exp=ffffffff", hi); end
      total++; if (lo !== 32'hFFFF_FFEB) begin bad++; $display("FAIL mult_neg_lo got=%h exp=ffffffeb", lo); end
      run_op(c_mult, 32'h8000_0000, 32'h8000_0000, lat, bc, hi, lo, whl, da);
      total++; if (hi !== 32'h4000_0000) begin bad++; $display("FAIL mult_min_hi got=%h exp=40000000", hi); end
      total++; if (lo !== 32'h0)         begin bad++; $display("FAIL mult_min_lo got=%h exp=00000000", lo); end
      total++; if (lat !== 34)           begin bad++; $display("FAIL mult_latency got=%0d exp=34", lat); end
   endtask

   task automatic test_div();
      int lat, bc; logic [31:0] hi, lo; logic whl, da;
      run_op(c_div, 32'hFFFF_FFF9, 32'd2, lat, bc, hi, lo, whl, da);
      total++; if (lo !== 32'hFFFF_FFFD) begin bad++; $display("FAIL div_neg_lo got=%h exp=fffffffd", lo); end
      total++; if (hi !== 32'hFFFF_FFFF) begin bad++; $display("FAIL div_neg_hi got=%h exp=ffffffff", hi); end
      run_op(c_divu, 32'd100, 32'd7, lat, bc, hi, lo, whl, da);
      total++; if (lo !== 32'd14)        begin bad++; $display("FAIL divu_lo got=%h exp=0000000e", lo); end
      total++; if (hi !== 32'd2)         begin bad++; $display("FAIL divu_hi got=%h exp=00000002", hi); end
      total++; if (lat !== 34)           begin bad++; $display("FAIL divu_latency got=%0d exp=34", lat); end
      run_op(c_div, 32'h8000_0000, 32'hFFFF_FFFF, lat, bc, hi, lo, whl, da);
      total++; if (lo !== 32'h8000_0000) begin bad++; $display("FAIL div_ovf_lo got=%h exp=80000000", lo); end
      total++; if (hi !== 32'h0)         begin bad++; $display("FAIL div_ovf_hi got=%h exp=00000000", hi); end
   endtask

   task automatic test_div_zero();
      int lat, bc; logic [31:0] hi, lo; logic whl, da;
      run_op(c_divu, 32'h0000_1234, 32'h0, lat, bc, hi, lo, whl, da);
      total++; if (lo !== 32'hFFFF_FFFF) begin bad++; $display("FAIL divu_zero_lo got=%h exp=ffffffff", lo); end
      total++; if (hi !== 32'h0000_1234) begin bad++; $display("FAIL divu_zero_hi got=%h exp=00001234", hi); end
      total++; if (lat !== 34)           begin bad++; $display("FAIL divu_zero_latency got=%0d exp=34", lat); end
      run_op(c_div, 32'hFFFF_FFFB, 32'h0, lat, bc, hi, lo, whl, da);
      total++; if (lo !== 32'hFFFF_FFFF) begin bad++; $display("FAIL div_zero_lo got=%h exp=ffffffff", lo); end
      total++; if (hi !== 32'hFFFF_FFFB) begin bad++; $display("FAIL div_zero_hi got=%h exp=fffffffb", hi); end
      total++; if (lat !== 34)           begin bad++; $display("FAIL div_zero_latency got=%0d exp=34", lat); end
   endtask

   task automatic test_back_to_back();
      int lat, bc; logic [31:0] hi, lo; logic whl, da;
      // MULTU 3*4 with a DIVU 9/3 request pulsed mid-CALC.
      bus.op = c_multu; bus.a = 32'd3; bus.b = 32'd4; bus.start = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      lat = 1;
      repeat (5) begin @(posedge clk); #1; lat++; end
      bus.op = c_divu; bus.a = 32'd9; bus.b = 32'd3; bus.start = 1'b1;
      @(posedge clk);
      #1;
      lat++;
      bus.start = 1'b0;
      while (!bus.done && lat < 100) begin @(posedge clk); #1; lat++; end
      total++; if (lat !== 34)     begin bad++; $display("FAIL ignored_start_latency got=%0d exp=34", lat); end
      total++; if (bus.lo !== 32'd12) begin bad++; $display("FAIL ignored_start_lo got=%h exp=0000000c", bus.lo); end
      total++; if (bus.hi !== 32'd0)  begin bad++; $display("FAIL ignored_start_hi got=%h exp=00000000", bus.hi); end
      @(posedge clk);
      #1;
      total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL ignored_start_not_queued got=%b exp=0", bus.busy); end
      // Now in the IDLE cycle right after done: accepted immediately.
      run_op(c_divu, 32'd100, 32'd7, lat, bc, hi, lo, whl, da);
      total++; if (lat !== 34)     begin bad++; $display("FAIL b2b_latency got=%0d exp=34", lat); end
      total++; if (lo !== 32'd14)  begin bad++; $display("FAIL b2b_lo got=%h exp=0000000e", lo); end
      total++; if (hi !== 32'd2)   begin bad++; $display("FAIL b2b_hi got=%h exp=00000002", hi); end
   endtask

   task automatic test_mid_reset();
      int lat, bc; logic [31:0] hi, lo; logic whl, da;
      bus.op = c_divu; bus.a = 32'd100; bus.b = 32'd7; bus.start = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL midrst_busy got=%b exp=0", bus.busy); end
      total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL midrst_done got=%b exp=0", bus.done); end
      total++; if (bus.hi !== 32'h0)  begin bad++; $display("FAIL midrst_hi got=%h exp=00000000", bus.hi); end
      total++; if (bus.lo !== 32'h0)  begin bad++; $display("FAIL midrst_lo got=%h exp=00000000", bus.lo); end
      rst = 1'b0;
      run_op(c_multu, 32'd5, 32'd6, lat, bc, hi, lo, whl, da);
      total++; if (lat !== 34)     begin bad++; $display("FAIL midrst_next_latency got=%0d exp=34", lat); end
      total++; if (lo !== 32'd30)  begin bad++; $display("FAIL midrst_next_lo got=%h exp=0000001e", lo); end
      total++; if (hi !== 32'd0)   begin bad++; $display("FAIL midrst_next_hi got=%h exp=00000000", hi); end
   endtask

   initial begin
      total = 0;
      bad   = 0;
      test_reset();
      test_multu();
      test_mult();
      test_div();
      test_div_zero();
      test_back_to_back();
      test_mid_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
